// File: rtl/addsub32_pipe.sv
// Two-stage pipelined WIDTH-bit adder/subtractor built from 4-bit CLA groups with valid/ready on both sides.
// Optional saturation of the result on signed overflow: define ADDSUB_SATURATE_EN.
`timescale 1ns/1ps

module addsub32_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned NG = HW / 4;
`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;
`endif

    // One 4-bit carry-look-ahead group: returns {c4, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = a ^ b;
        g  = a & b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // Half-width add: CLA groups with carries rippling between groups, returns {cout, sum}.
    function automatic logic [HW:0] add_half(input logic [HW-1:0] a, input logic [HW-1:0] b, input logic cin);
        logic [HW-1:0] s;
        logic [4:0]    r;
        logic          c;
        s = '0;
        c = cin;
        for (int i = 0; i < int'(NG); i++) begin
            r          = cla4(a[4*i +: 4], b[4*i +: 4], c);
            s[4*i +: 4] = r[3:0];
            c          = r[4];
        end
        return {c, s};
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic [HW-1:0] s1_lo_q, s1_lo_d;
    logic          s1_c_q, s1_c_d;
    logic [HW-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [HW-1:0] s1_b_hi_q, s1_b_hi_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_zero_q, out_zero_d;
    logic             out_neg_q, out_neg_d;

    logic             s2_adv, s1_adv, in_fire;
    logic [WIDTH-1:0] b_x;
    logic [HW:0]      lo_res, hi_res;
    logic [WIDTH-1:0] raw_sum, fin_sum;
    logic             raw_ovf;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    // Stage 1: lower half sum and half carry; capture upper operand halves.
    always_comb begin
        b_x        = in_sub ? ~in_b : in_b;
        lo_res     = add_half(in_a[HW-1:0], b_x[HW-1:0], in_sub);
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_c_d     = s1_c_q;
        s1_a_hi_d  = s1_a_hi_q;
        s1_b_hi_d  = s1_b_hi_q;
        if (s1_adv) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_lo_d   = lo_res[HW-1:0];
                s1_c_d    = lo_res[HW];
                s1_a_hi_d = in_a[WIDTH-1:HW];
                s1_b_hi_d = b_x[WIDTH-1:HW];
            end
        end
    end

    // Stage 2: upper half from registered operands, then flags (and optional saturation).
    always_comb begin
        hi_res  = add_half(s1_a_hi_q, s1_b_hi_q, s1_c_q);
        raw_sum = {hi_res[HW-1:0], s1_lo_q};
        raw_ovf = (s1_a_hi_q[HW-1] == s1_b_hi_q[HW-1]) && (raw_sum[WIDTH-1] != s1_a_hi_q[HW-1]);
`ifdef ADDSUB_SATURATE_EN
        fin_sum = raw_ovf ? (s1_a_hi_q[HW-1] ? SAT_NEG : SAT_POS) : raw_sum;
`else
        fin_sum = raw_sum;
`endif
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        out_zero_d  = out_zero_q;
        out_neg_d   = out_neg_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sum_d   = fin_sum;
                out_carry_d = hi_res[HW];
                out_ovf_d   = raw_ovf;
                out_zero_d  = (fin_sum == '0);
                out_neg_d   = fin_sum[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_c_q      <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_c_q      <= s1_c_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
            out_neg_q   <= out_neg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign out_zero  = out_zero_q;
    assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_addsub32_pipe.sv
// Self-checking bench for addsub32_pipe: directed vector table, backpressure, streaming and reset sequences.
`timescale 1ns/1ps

module tb_addsub32_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic         out_carry, out_ovf, out_zero, out_neg;
    logic [W-1:0] in_a, in_b, out_sum;

    always #5 clk = ~clk;

    addsub32_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_neg(out_neg)
    );

    typedef struct {
        logic [31:0] sum;
        logic        c, v, z, n;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        sub;
        logic [31:0] sum;
        logic        c, v, z, n;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    bit   lat_chk = 1'b0;
    exp_t q[$];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [31:0] bx;
        logic [32:0] r;
        bx    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, bx} + 33'(sub);
        e.sum = r[31:0];
        e.c   = r[32];
        e.v   = (a[31] == bx[31]) && (r[31] != a[31]);
`ifdef ADDSUB_SATURATE_EN
        if (e.v) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.z   = (e.sum == 32'h0);
        e.n   = e.sum[31];
        e.cyc = 0;
        return e;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Negedge sample plus scoreboard update for transfers happening at the coming edge.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got out_sum %h with no pending op", out_sum);
                end else begin
                    e = q.pop_front();
                    check32("sb_sum", out_sum, e.sum);
                    check1("sb_carry", out_carry, e.c);
                    check1("sb_ovf", out_ovf, e.v);
                    check1("sb_zero", out_zero, e.z);
                    check1("sb_neg", out_neg, e.n);
                    if (lat_chk) check32("sb_latency", 32'(cyc - e.cyc), 32'd2);
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                e     = model(in_a, in_b, in_sub);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[10];
        logic [31:0] bp_a[4];
        logic [31:0] bp_b[4];
        logic        bp_s[4];
        logic [31:0] hold;

`ifdef ADDSUB_SATURATE_EN
        vt[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vt[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        bp_a = '{32'h0000_0001, 32'h0000_000A, 32'hFFFF_0000, 32'h0000_0000};
        bp_b = '{32'h0000_0002, 32'h0000_0003, 32'h0001_0000, 32'h0000_0000};
        bp_s = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) begin next(); sample(); end
        next(); rst = 1'b0; sample();
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
        check32("rst_out_sum", out_sum, 32'h0);
        check1("rst_carry", out_carry, 1'b0);
        check1("rst_ovf", out_ovf, 1'b0);
        check1("rst_zero", out_zero, 1'b0);
        check1("rst_neg", out_neg, 1'b0);

        // Directed table: one op at a time, result must show exactly two cycles later.
        for (int i = 0; i < 10; i++) begin
            next(); in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; in_sub = vt[i].sub;
            sample();
            check1($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            next(); in_valid = 1'b0;
            sample();
            check1($sformatf("vec%0d_early_valid", i), out_valid, 1'b0);
            next();
            sample();
            check1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            check32($sformatf("vec%0d_sum", i), out_sum, vt[i].sum);
            check1($sformatf("vec%0d_carry", i), out_carry, vt[i].c);
            check1($sformatf("vec%0d_ovf", i), out_ovf, vt[i].v);
            check1($sformatf("vec%0d_zero", i), out_zero, vt[i].z);
            check1($sformatf("vec%0d_neg", i), out_neg, vt[i].n);
        end
        next(); sample();

        // Backpressure: out_ready low for five cycles while four ops are offered.
        next(); out_ready = 1'b0; in_valid = 1'b1; in_a = bp_a[0]; in_b = bp_b[0]; in_sub = bp_s[0];
        sample();
        check1("bp_ready0", in_ready, 1'b1);
        next(); in_a = bp_a[1]; in_b = bp_b[1]; in_sub = bp_s[1];
        sample();
        check1("bp_ready1", in_ready, 1'b1);
        next(); in_a = bp_a[2]; in_b = bp_b[2]; in_sub = bp_s[2];
        sample();
        check1("bp_ready_drop", in_ready, 1'b0);
        check1("bp_valid", out_valid, 1'b1);
        check32("bp_first_sum", out_sum, 32'h0000_0003);
        hold = out_sum;
        repeat (2) begin
            next(); sample();
            check1("bp_stall_ready", in_ready, 1'b0);
            check1("bp_stall_valid", out_valid, 1'b1);
            check32("bp_stall_sum", out_sum, hold);
        end
        next(); out_ready = 1'b1;
        sample();
        check1("bp_drain_ready", in_ready, 1'b1);
        check1("bp_drain_v0", out_valid, 1'b1);
        next(); in_a = bp_a[3]; in_b = bp_b[3]; in_sub = bp_s[3];
        sample();
        check1("bp_drain_v1", out_valid, 1'b1);
        check32("bp_drain_sum1", out_sum, 32'h0000_0007);
        next(); in_valid = 1'b0;
        sample();
        check1("bp_drain_v2", out_valid, 1'b1);
        check1("bp_drain_zero2", out_zero, 1'b1);
        next(); sample();
        check1("bp_drain_v3", out_valid, 1'b1);
        next(); sample();
        check1("bp_drain_empty", out_valid, 1'b0);
        check32("bp_sb_empty", 32'(q.size()), 32'd0);

        // Streaming: 100 random ops back to back.
        lat_chk = 1'b1; out_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            next(); in_valid = 1'b1; in_a = $urandom(); in_b = $urandom(); in_sub = 1'($urandom_range(1, 0));
            sample();
            if (i >= 2) check1("stream_every_cycle", out_valid, 1'b1);
        end
        next(); in_valid = 1'b0; sample();
        repeat (3) begin next(); sample(); end
        check32("stream_count", 32'(out_cnt), 32'd100);
        check32("stream_sb_empty", 32'(q.size()), 32'd0);
        lat_chk = 1'b0;

        // Reset with both stages full and a new op offered in the reset cycle.
        next(); out_ready = 1'b0; in_valid = 1'b1; in_a = 32'd7; in_b = 32'd8; in_sub = 1'b0;
        sample();
        next(); in_a = 32'd20; in_b = 32'd1; in_sub = 1'b1;
        sample();
        next(); rst = 1'b1; in_a = 32'd100; in_b = 32'd1; in_sub = 1'b0;
        sample();
        check1("rstmid_full_valid", out_valid, 1'b1);
        check1("rstmid_full_ready", in_ready, 1'b0);
        next(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sample();
        check1("rstmid_out_valid", out_valid, 1'b0);
        check1("rstmid_in_ready", in_ready, 1'b1);
        check32("rstmid_out_sum", out_sum, 32'h0);
        repeat (4) begin
            next(); sample();
            check1("rstmid_no_stale", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
